// File: rtl/cpu_seg_mux_alu.sv
// Switch-driven ALU with an execute button and a multiplexed hex readout.
// Result is shown as magnitude; the last digit's dp flags a negative difference.
module cpu_seg_mux_alu #(
    parameter int OPW         = 4,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*OPW+1:0]    sw,
    input  logic                btn_exec,
    output logic [DIGITS-1:0]   an,
    output logic [7:0]          seg,
    output logic [2*OPW-1:0]    result_o,
    output logic                neg_o
);
    localparam int RW = 2 * OPW;
    localparam int PW = DIGITS * 4;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);

    if (PW < RW) begin : g_bad_digits
        $error("DIGITS*4 must cover the result width");
    end
    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be at least 2");
    end

    logic              sync1_q, sync2_q, prev_q;
    logic              exec_pulse;
    logic [1:0]        op;
    logic [RW-1:0]     a_x, b_x;
    logic [RW-1:0]     result_q, result_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic [PW-1:0]     res_pad;
    logic [3:0]        nib;
    logic              upper_zero;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign exec_pulse = sync2_q & ~prev_q;
    assign op  = sw[2*OPW+1:2*OPW];
    assign a_x = {{OPW{1'b0}}, sw[2*OPW-1:OPW]};
    assign b_x = {{OPW{1'b0}}, sw[OPW-1:0]};

    always_comb begin
        result_d = result_q;
        neg_d    = neg_q;
        if (exec_pulse) begin
            neg_d = 1'b0;
            unique case (op)
                2'b00: result_d = a_x + b_x;
                2'b01: begin
                    if (a_x >= b_x) begin
                        result_d = a_x - b_x;
                    end else begin
                        result_d = b_x - a_x;
                        neg_d    = 1'b1;
                    end
                end
                2'b10: result_d = a_x * b_x;
                default: result_d = a_x | b_x;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Blanking looks at every nibble from the active digit upward.
    always_comb begin
        res_pad          = '0;
        res_pad[RW-1:0]  = result_q;
        nib              = 4'h0;
        upper_zero       = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_q == IW'(d)) begin
                nib        = res_pad[4*d +: 4];
                upper_zero = ((res_pad >> (4 * d)) == '0);
            end
        end
        an_d       = ~(DIGITS'(1) << idx_q);
        seg_d[6:0] = hex7(nib);
        if (BLANK_LZ && (idx_q != '0) && upper_zero) begin
            seg_d[6:0] = 7'h7F;
        end
        seg_d[7] = ~(neg_q && (idx_q == IW'(DIGITS - 1)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            result_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            an_q     <= '1;
            seg_q    <= 8'hFF;
        end else begin
            sync1_q  <= btn_exec;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            result_q <= result_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign result_o = result_q;
    assign neg_o    = neg_q;

endmodule

// File: tb/tb_cpu_seg_mux_alu.sv
// Randomised and directed checks of cpu_seg_mux_alu against an
// edge-counting behavioural model of the ALU and display scan.
module tb_cpu_seg_mux_alu;
    localparam int OPW = 4;
    localparam int DG  = 4;
    localparam int RD  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2*OPW+1:0] sw;
    logic             btn_exec;
    logic [DG-1:0]    an;
    logic [7:0]       seg;
    logic [2*OPW-1:0] result_o;
    logic             neg_o;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_seg_mux_alu #(
        .OPW(OPW), .DIGITS(DG), .REFRESH_DIV(RD), .BLANK_LZ(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn_exec(btn_exec),
        .an(an), .seg(seg), .result_o(result_o), .neg_o(neg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                              7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                              7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [7:0] exp_seg(input int unsigned r,
                                           input bit ng, input int d);
        int unsigned up;
        logic [6:0]  s;
        logic        dp;
        up = r >> (4 * d);
        s  = font[up & 15];
        if (d > 0 && up == 0) s = 7'h7F;
        dp = (ng && d == DG - 1) ? 1'b0 : 1'b1;
        return {dp, s};
    endfunction

    // Model: n counts edges since reset; btn history queue, newest first.
    bit          armed = 0;
    int unsigned n;
    bit          bh[$];
    int unsigned m_res;
    bit          m_neg;
    logic [3:0]  m_an;
    logic [7:0]  m_seg;

    always @(posedge clk) begin
        int unsigned a, b, d;
        if (!rst_n) begin
            armed = 1;
            m_an  = 4'hF;
            m_seg = 8'hFF;
            m_res = 0;
            m_neg = 0;
            n     = 0;
            bh    = '{0, 0, 0};
        end else if (armed) begin
            d     = (n / RD) % DG;
            m_an  = ~(4'b1 << d);
            m_seg = exp_seg(m_res, m_neg, int'(d));
            if (bh[1] && !bh[2]) begin
                a = sw[7:4];
                b = sw[3:0];
                m_neg = 0;
                case (sw[9:8])
                    2'd0: m_res = a + b;
                    2'd1: if (a >= b) m_res = a - b;
                          else begin m_res = b - a; m_neg = 1; end
                    2'd2: m_res = a * b;
                    default: m_res = a | b;
                endcase
            end
            n++;
            bh.push_front(btn_exec);
            void'(bh.pop_back());
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("an", 32'(an), 32'(m_an));
            chk("seg", 32'(seg), 32'(m_seg));
            chk("result", 32'(result_o), m_res);
            chk("neg", 32'(neg_o), 32'(m_neg));
        end
    end

    task automatic wait_dig(input int d);
        logic [3:0] want;
        int k;
        want = ~(4'b1 << d);
        k = 0;
        while (an !== want && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (an !== want) chk("dig_timeout", 32'(an), 32'(want));
    endtask

    task automatic press(input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b);
        sw = {op, a, b};
        btn_exec = 1'b1;
        @(negedge clk);
        btn_exec = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        btn_exec = 1'b0;
        sw = '0;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_res", 32'(result_o), 32'h0);
        chk("rst_neg", 32'(neg_o), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_an", 32'(an), 32'hE);
        chk("rel_seg", 32'(seg), 32'hC0);
        repeat (16) @(negedge clk);

        press(2'b00, 4'h9, 4'h8);
        chk("add_res", 32'(result_o), 32'h11);
        wait_dig(0); chk("add_d0", 32'(seg), 32'hF9);
        wait_dig(1); chk("add_d1", 32'(seg), 32'hF9);
        wait_dig(2); chk("add_d2", 32'(seg), 32'hFF);

        press(2'b01, 4'h3, 4'h5);
        chk("subn_res", 32'(result_o), 32'h02);
        chk("subn_neg", 32'(neg_o), 32'h1);
        wait_dig(0); chk("subn_d0", 32'(seg), 32'hA4);
        wait_dig(3); chk("subn_d3", 32'(seg), 32'h7F);

        press(2'b01, 4'h5, 4'h3);
        chk("subp_neg", 32'(neg_o), 32'h0);
        wait_dig(3); chk("subp_d3", 32'(seg), 32'hFF);

        press(2'b10, 4'hF, 4'hF);
        chk("mul_res", 32'(result_o), 32'hE1);
        wait_dig(0); chk("mul_d0", 32'(seg), 32'hF9);
        wait_dig(1); chk("mul_d1", 32'(seg), 32'h86);

        press(2'b11, 4'hA, 4'h5);
        chk("or_res", 32'(result_o), 32'h0F);
        wait_dig(0); chk("or_d0", 32'(seg), 32'h8E);
        wait_dig(1); chk("or_d1", 32'(seg), 32'hFF);

        sw = {2'b00, 4'h1, 4'h2};
        btn_exec = 1'b1;
        repeat (10) @(negedge clk);
        sw = {2'b00, 4'h7, 4'h7};
        repeat (10) @(negedge clk);
        btn_exec = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_res", 32'(result_o), 32'h3);

        sw = {2'b11, 4'h1, 4'h2};
        btn_exec = 1'b1;
        repeat (3) @(negedge clk);
        btn_exec = 1'b0;
        sw = {2'b00, 4'h4, 4'h4};
        @(negedge clk);
        btn_exec = 1'b1;
        repeat (3) @(negedge clk);
        btn_exec = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch_res", 32'(result_o), 32'h8);

        wait_dig(2);
        sw = {2'b00, 4'h1, 4'h1};
        btn_exec = 1'b1;
        @(negedge clk);
        btn_exec = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_res", 32'(result_o), 32'h0);
        chk("mrst_neg", 32'(neg_o), 32'h0);
        chk("mrst_an", 32'(an), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_rel_an", 32'(an), 32'hE);

        for (int i = 0; i < 600; i++) begin
            sw       = 10'($urandom);
            btn_exec = ($urandom_range(0, 3) == 0);
            rst_n    = ($urandom_range(0, 99) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        btn_exec = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
